// File: rtl/tetris_input.sv
// tetris_input: button conditioning and command arbitration for a Tetris core.
// Four raw buttons are synchronised and debounced. Rising debounced levels,
// plus a run-gated gravity timer, set saturating pending bits. A small FSM
// issues one prioritised command strobe at a time, followed by an idle gap.
// Optional build macro HOLD_REPEAT_EN: auto-repeat of left/right/down while held.
module tetris_input #(
   parameter int unsigned DEB_CYCLES     = 1000000,
   parameter int unsigned GRAVITY_CYCLES = 50000000,
   parameter int unsigned MIN_GAP        = 256,
   parameter int unsigned REPEAT_DELAY   = 30000000,
   parameter int unsigned REPEAT_PERIOD  = 10000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] btn,
   input  logic       run,
   output logic       ctrl_valid,
   output logic [1:0] ctrl
);

   localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
   localparam int unsigned GRAV_W = $clog2(GRAVITY_CYCLES + 1);
   localparam int unsigned GAP_W  = $clog2(MIN_GAP + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t             state;
   logic [3:0]         sync1;
   logic [3:0]         sync2;
   logic [3:0]         level;
   logic [DEB_W-1:0]   deb_cnt [4];
   logic [3:0]         rise_c;
   logic [3:0]         ev_c;
   logic [3:0]         pend;
   logic               grav_pend;
   logic [GRAV_W-1:0]  grav_cnt;
   logic               grav_ev_c;
   logic [GAP_W-1:0]   gap_cnt;
   logic [1:0]         code_c;
   logic [3:0]         clr_c;
   logic               clr_grav_c;
   logic               take_c;
   logic               take_down_c;

   // Two-flop synchroniser on every raw button
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Per-button debounce: level flips after DEB_CYCLES consecutive differing cycles
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level <= '0;
         for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == level[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
               level[i]   <= ~level[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            end
         end
      end
   end

   // Debounced 0->1 transitions, valid in the cycle the level is about to flip
   always_comb begin
      rise_c = '0;
      for (int i = 0; i < 4; i++)
         rise_c[i] = !level[i] && sync2[i] && (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1));
   end

`ifdef HOLD_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_cnt [3];
   logic [2:0]       rep_armed;
   logic [2:0]       rep_ev_c;

   // Repeat event after REPEAT_DELAY of hold, then every REPEAT_PERIOD (right, down, left)
   always_comb begin
      rep_ev_c = '0;
      for (int i = 0; i < 3; i++)
         rep_ev_c[i] = level[i] && (rep_cnt[i] == (rep_armed[i] ? REP_W'(REPEAT_PERIOD - 1)
                                                                : REP_W'(REPEAT_DELAY - 1)));
   end

   // Hold-time counters, cleared on release
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rep_armed <= '0;
         for (int i = 0; i < 3; i++) rep_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!level[i]) begin
               rep_cnt[i]   <= '0;
               rep_armed[i] <= 1'b0;
            end else if (rep_ev_c[i]) begin
               rep_cnt[i]   <= '0;
               rep_armed[i] <= 1'b1;
            end else begin
               rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
            end
         end
      end
   end

   assign ev_c = rise_c | {1'b0, rep_ev_c};
`else
   assign ev_c = rise_c;
`endif

   assign grav_ev_c = run && (grav_cnt == GRAV_W'(GRAVITY_CYCLES - 1));

   // Gravity timer; a serviced down command makes the service cycle cycle 0 of a new period
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         grav_cnt <= '0;
      end else if (take_down_c) begin
         grav_cnt <= run ? GRAV_W'(1) : '0;
      end else if (run) begin
         grav_cnt <= grav_ev_c ? '0 : grav_cnt + GRAV_W'(1);
      end
   end

   // Priority pick: rotate > left > right > down (button or gravity)
   always_comb begin
      code_c     = 2'b00;
      clr_c      = '0;
      clr_grav_c = 1'b0;
      if (pend[3]) begin
         code_c   = 2'b11;
         clr_c[3] = 1'b1;
      end else if (pend[2]) begin
         code_c   = 2'b10;
         clr_c[2] = 1'b1;
      end else if (pend[0]) begin
         code_c   = 2'b00;
         clr_c[0] = 1'b1;
      end else if (pend[1] || grav_pend) begin
         code_c     = 2'b01;
         clr_c[1]   = 1'b1;
         clr_grav_c = 1'b1;
      end
      take_c      = (state == IDLE) && ((|pend) || grav_pend);
      take_down_c = take_c && clr_grav_c;
   end

   // Command FSM and pending bits; a new event in the service cycle keeps its bit set
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         ctrl_valid <= 1'b0;
         ctrl       <= 2'b00;
         gap_cnt    <= '0;
         pend       <= '0;
         grav_pend  <= 1'b0;
      end else begin
         ctrl_valid <= 1'b0;
         pend       <= (pend & ~(take_c ? clr_c : 4'b0000)) | ev_c;
         grav_pend  <= (grav_pend & ~take_down_c) | grav_ev_c;
         case (state)
            IDLE: begin
               if (take_c) begin
                  ctrl  <= code_c;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               ctrl_valid <= 1'b1;
               gap_cnt    <= '0;
               state      <= GAP;
            end
            GAP: begin
               if (gap_cnt == GAP_W'(MIN_GAP - 1)) state <= IDLE;
               else gap_cnt <= gap_cnt + GAP_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/tetris_input.md
TETRIS_INPUT -- requirements
Module: tetris_input

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, meaning consecutive cycles a raw button must differ from its debounced level before the level flips.
REQ-002 SHALL have parameter GRAVITY_CYCLES, default 50000000, meaning the period between automatic down requests while run=1.
REQ-003 SHALL have parameter MIN_GAP, default 256, meaning the minimum idle cycles enforced after each issued command.
REQ-004 SHALL have parameter REPEAT_DELAY, default 30000000, meaning the hold time before the first auto-repeat.
REQ-005 SHALL have parameter REPEAT_PERIOD, default 10000000, meaning the interval between later auto-repeats.
REQ-006 clk  input  1  sole clock; all state on posedge clk.
REQ-007 reset_n  input  1  synchronous, active-low reset.
REQ-008 btn  input  4  raw asynchronous buttons; [3]=rotate, [2]=left, [1]=down, [0]=right; active-high.
REQ-009 run  input  1  gravity enable; the gravity counter advances only while run=1.
REQ-010 ctrl_valid  output  1  one-cycle command strobe to the game core.
REQ-011 ctrl  output  2  command code, meaningful only while ctrl_valid=1: 11 rotate, 10 left, 01 down, 00 right.

Function
REQ-012 Each btn bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-013 Each button SHALL have its own counter; the counter clears whenever the synced input equals the debounced level, and the level flips when the counter reaches DEB_CYCLES.
REQ-014 A 0->1 transition of a debounced level SHALL set that button's pending bit.
REQ-015 The gravity counter SHALL count while run=1, hold while run=0, set the gravity pending bit on reaching GRAVITY_CYCLES-1, and wrap to 0.
REQ-016 Pending bits SHALL saturate, so multiple events from one source before service yield a single command.
REQ-017 The FSM SHALL have three states: IDLE, ISSUE and GAP.
REQ-018 In IDLE, if any pending bit is set, the FSM SHALL latch the winning code into ctrl and enter ISSUE.
REQ-019 In ISSUE, the block SHALL drive ctrl_valid=1 for exactly one cycle, then enter GAP.
REQ-020 Commands SHALL be issued in this priority order: rotate > left > right > down (either the down button or gravity).
REQ-021 One down command SHALL clear both the down-button pending bit and the gravity pending bit.
REQ-022 Issuing any down command SHALL restart the gravity counter at 0.
REQ-023 In GAP, the FSM SHALL count MIN_GAP cycles and then return to IDLE; new events arriving in GAP or ISSUE SHALL only set pending bits.
REQ-024 Latency from a pending bit being set while in IDLE to ctrl_valid=1 SHALL be 2 cycles.
REQ-025 The spacing between consecutive strobes SHALL be at least MIN_GAP+2 cycles.
REQ-026 ctrl SHALL hold its last value outside strobes.
REQ-027 When a new pending event and service of the same source occur in the same cycle, the new event SHALL win and the bit SHALL stay set.

Reset
REQ-028 While reset_n=0 at posedge clk, the following SHALL be cleared: ctrl_valid=0, ctrl=00, FSM=IDLE, all pending bits, debounced levels, synchronisers, debounce counters, gravity, repeat and gap counters.
REQ-029 A reset asserted mid-ISSUE or mid-GAP SHALL suppress any strobe on the next cycle, and no command pending before reset SHALL be issued after it.

Configuration
REQ-030 When HOLD_REPEAT_EN is defined, holding left, right or down debounced-high for REPEAT_DELAY cycles SHALL set its pending bit, and then again every REPEAT_PERIOD cycles until release; rotate SHALL never repeat.
REQ-031 When HOLD_REPEAT_EN is undefined, the repeat counters and parameters SHALL be unused, and exactly one command SHALL result per press.

Verification (DEB_CYCLES=4, GRAVITY_CYCLES=100, MIN_GAP=8, REPEAT_DELAY=40, REPEAT_PERIOD=20)
REQ-032 Press btn[2] cleanly for 50 cycles -> exactly one ctrl_valid with ctrl=10; no strobe on release.
REQ-033 Bounce btn[3] 1-0-1-0 on 2-cycle pulses, then hold steady -> exactly one ctrl=11 strobe after the stable hold.
REQ-034 Press rotate, left and right in the same cycle -> strobes 11, 10, 00 in order, each spaced >=10 cycles.
REQ-035 run=1 with no buttons -> ctrl=01 strobe every 100 cycles; a down press at cycle 50 -> the next gravity strobe comes 100 cycles after the button strobe.
REQ-036 Pulse reset_n=0 for one cycle during GAP with left pending -> no strobe afterwards until a new press.
REQ-037 With HOLD_REPEAT_EN, hold btn[0] for 100 cycles -> ctrl=00 strobes at press, +~40, +~60 and +~80 cycles; without HOLD_REPEAT_EN -> a single strobe.
